// File: rtl/display_scanner.sv
// Time-multiplexed 4-digit hex scanner for a common-anode seven-segment display.
// Holds a tear-free display value, inserts an anti-ghosting guard at the start
// of every slot and optionally blanks leading zeros.
module display_scanner #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 1000,
  parameter int unsigned LZB         = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value_in,
  output logic [3:0]  num,
  output logic [3:0]  anode_active,
  output logic [1:0]  digit_sel,
  output logic        pending
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);
  localparam bit LZB_ON = (LZB != 0);

  logic [PW-1:0] prescaler;
  logic [15:0]   disp_reg;
  logic [15:0]   pend_reg;
  logic          tick;
  logic          frame_end;
  logic          in_guard;
  logic          lz_blank;

  assign tick      = (prescaler == LAST);
  assign frame_end = tick && (digit_sel == 2'd3);

  // Slot prescaler: wraps every REFRESH_DIV cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  // Slot index advances once per prescaler wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_sel <= 2'd0;
    end else if (tick) begin
      digit_sel <= digit_sel + 2'd1;
    end
  end

  // Capture loads into a shadow register; commit only at the frame boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_reg <= 16'h0000;
      disp_reg <= 16'h0000;
      pending  <= 1'b0;
    end else begin
      if (load) begin
        pend_reg <= value_in;
      end
      if (frame_end) begin
        pending <= 1'b0;
        if (load) begin
          disp_reg <= value_in;
        end else if (pending) begin
          disp_reg <= pend_reg;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Guard interval at the start of each slot (absent when GUARD is zero)
  generate
    if (GUARD == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (prescaler < PW'(GUARD));
    end
  endgenerate

  // Nibble select and leading-zero detection for the current slot
  always_comb begin
    num      = 4'h0;
    lz_blank = 1'b0;
    case (digit_sel)
      2'd0: num = disp_reg[3:0];
      2'd1: begin
        num      = disp_reg[7:4];
        lz_blank = LZB_ON && (disp_reg[15:4] == 12'h000);
      end
      2'd2: begin
        num      = disp_reg[11:8];
        lz_blank = LZB_ON && (disp_reg[15:8] == 8'h00);
      end
      default: begin
        num      = disp_reg[15:12];
        lz_blank = LZB_ON && (disp_reg[15:12] == 4'h0);
      end
    endcase
  end

  // At most one active-low anode; all off while disabled, guarded or blanked
  always_comb begin
    anode_active = 4'b1111;
    if (en && !in_guard && !lz_blank) begin
      anode_active[digit_sel] = 1'b0;
    end
  end

endmodule
